apb_rr_master_arb: RTL and testbench
====================================

# apb_rr_master_arb

Round-robin arbiter and APB master sequencer that shares one APB bus among `NUM_REQ` requesters. It sits in the APB VIP environment between the requesters (bridge model, register sequencer) and the APB slave. It grants one requester at a time, drives the SETUP/ACCESS phases, waits out `pready` wait states, and returns read data and error status to the granted requester.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `C_APB_ADDR_WIDTH`, 32: `paddr` width.
- `C_APB_DATA_WIDTH`, 32: `pwdata`/`prdata` width.
- `TIMEOUT_CYCLES`, 16: ACCESS wait-state limit, 1..255; used only with `APB_ARB_TIMEOUT_EN`.
- `APB_ACLK` in 1: the only clock; all logic on its rising edge.
- `APB_ARESET_N` in 1: synchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester transfer request.
- `req_ready` out NUM_REQ: one-hot grant/accept pulse.
- `req_addr` in NUM_REQ*ADDR_W: flattened; requester i uses slice [i*ADDR_W +: ADDR_W].
- `req_write` in NUM_REQ: 1 = write.
- `req_wdata` in NUM_REQ*DATA_W: flattened as for `req_addr`.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle completion pulse.
- `rsp_rdata` out DATA_W: read data; shared by all requesters.
- `rsp_err` out 1: error status; shared by all requesters.
- `paddr` out ADDR_W; `pwrite` out 1; `psel` out 1; `penable` out 1; `pwdata` out DATA_W: APB master outputs.
- `prdata` in DATA_W; `pready` in 1; `pslverr` in 1: APB slave responses.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- **Grant point:** IDLE with any `req_valid`, or the ACCESS completion cycle with any `req_valid`.
  - Winner is the first set `req_valid` at or after `rr_ptr`, searching upward with wrap.
  - `req_ready[winner]` is asserted combinationally in that cycle.
  - The winner's addr/write/wdata are registered onto `paddr`/`pwrite`/`pwdata`.
  - `rr_ptr` becomes (winner+1) mod NUM_REQ.
  - Next state is SETUP.
- **SETUP:** `psel`=1, `penable`=0. Always lasts one cycle; next state is ACCESS.
- **ACCESS:** `psel`=1, `penable`=1. The FSM holds until `pready`=1.
  - **On completion:** `rsp_valid[owner]`=1 in the next cycle.
  - `rsp_rdata` = sampled `prdata` for reads, 0 for writes.
  - `rsp_err` = sampled `pslverr`.
  - **Next state:** SETUP if a new grant is made, else IDLE with `psel`=`penable`=0.
- Requesters hold `req_valid` and payload stable until `req_ready`. A requester may drop `req_valid` before being granted.
- `paddr`/`pwrite`/`pwdata` stay stable from SETUP through the last ACCESS cycle. They keep their last values while IDLE.
- A requester with an outstanding transfer may re-request. It is re-granted only after `rsp_valid` or in the same completion cycle, subject to round-robin order.
- **Reset (including mid-transfer):**
  - `psel`, `penable`, `paddr`, `pwrite`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err` = 0.
  - `req_ready` forced to 0 while `APB_ARESET_N`=0.
  - `rr_ptr`=0; state IDLE.
  - An aborted transfer produces no response.

## Timing
- Zero wait states:
  - Grant at cycle N.
  - SETUP at N+1, ACCESS at N+2 with `pready`=1.
  - `rsp_valid` at N+3.
- Each `pready`=0 cycle in ACCESS adds one cycle.
- Back-to-back transfers: 2 bus cycles each. `psel` stays high continuously and `penable` toggles 0/1.
- Outputs are registered except `req_ready`.
- `rsp_*` is a single-cycle pulse with no backpressure; the requester must accept it.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter counts consecutive ACCESS cycles with `pready`=0.
  - When it reaches `TIMEOUT_CYCLES`, the transfer terminates: `psel`/`penable` drop (or go to SETUP for a pending grant).
  - That requester gets `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0.
  - `pready`=1 on the same cycle the limit is reached is a normal completion; pready wins.
  - The counter clears on entry to SETUP and on reset.
- Undefined: ACCESS waits indefinitely; no counter logic is present.

## Test plan
- **Single read, NUM_REQ=2:** req0 reads 0x0000_0010; slave returns `prdata`=0xDEAD_BEEF with zero wait states. Expect `req_ready[0]` at N, `psel` at N+1, `penable` at N+2, `rsp_valid[0]` at N+3 with `rsp_rdata`=0xDEAD_BEEF and `rsp_err`=0.
- **Round-robin:** req0 and req1 continuously request writes to 0x4/0x8. Expect grant order 0,1,0,1, `psel` continuously high, 2 cycles per transfer.
- **Wait states plus error:** write 0x1234_5678 to 0x20; slave holds `pready`=0 for 3 cycles, then `pready`=1 with `pslverr`=1. Expect `pwdata` stable for 4 ACCESS cycles, then `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0.
- **Reset mid-ACCESS:** assert `APB_ARESET_N`=0 during a wait state. The next cycle has all outputs at 0 and no `rsp_valid`. After reset, req1 and req0 request together and req0 wins.
- **Timeout, `APB_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=4:** slave never asserts `pready`. After 4 ACCESS cycles `psel` drops, then `rsp_valid` with `rsp_err`=1. Repeat with `pready`=1 on the 4th cycle and expect normal completion with `rsp_err`=0.

Source files
------------

// File: rtl/apb_rr_master_arb_if.sv
// Requester-side and APB-side signal bundle for apb_rr_master_arb.
// The master modport is the arbiter; the slave modport is the requesters and APB slave.
interface apb_rr_master_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    logic [ADDR_W-1:0]         paddr;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [DATA_W-1:0]         pwdata;
    logic [DATA_W-1:0]         prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwrite, psel, penable, pwdata
    );
endinterface

// File: rtl/apb_rr_master_arb.sv
// Round-robin arbiter + APB master sequencer sharing one APB bus among NUM_REQ requesters.
// Optional ACCESS wait-state timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_rr_master_arb #(
    parameter int NUM_REQ          = 2,
    parameter int C_APB_ADDR_WIDTH = 32,
    parameter int C_APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                 APB_ACLK,
    input  logic                 APB_ARESET_N,
    apb_rr_master_arb_if.master  bus
);
    localparam int AW    = C_APB_ADDR_WIDTH;
    localparam int DW    = C_APB_DATA_WIDTH;
    localparam int PTR_W = $clog2(NUM_REQ);

    // Encoding makes psel/penable straight flop outputs: bit0 = psel, bit1 = penable.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
    } req_t;

    state_t                   state, state_nxt;
    req_t [NUM_REQ-1:0]       req;
    logic [PTR_W-1:0]         rr_ptr, rr_ptr_nxt, winner, owner;
    logic                     any_req, grant_pt, done, tmo;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     psel, penable;

    logic [AW-1:0]            paddr;
    logic                     pwrite;
    logic [DW-1:0]            pwdata;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [DW-1:0]            rsp_rdata;
    logic                     rsp_err;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req[i] = '{addr:  bus.req_addr[i*AW +: AW],
                          write: bus.req_write[i],
                          wdata: bus.req_wdata[i*DW +: DW]};
    end

    assign any_req  = |bus.req_valid;
    assign done     = (state == ACCESS) && (bus.pready || tmo);
    assign grant_pt = any_req && ((state == IDLE) || done);

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        logic found;
        int   idx;
        found  = 1'b0;
        idx    = 0;
        winner = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    assign rr_ptr_nxt = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + PTR_W'(1);

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge APB_ACLK) begin
        if (!APB_ARESET_N)                       wait_cnt <= '0;
        else if (grant_pt)                       wait_cnt <= '0;
        else if (state == ACCESS && !bus.pready) wait_cnt <= wait_cnt + 8'd1;
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive not-ready ACCESS cycle; pready wins.
    assign tmo = (state == ACCESS) && !bus.pready &&
                 (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge APB_ACLK) begin
        if (!APB_ARESET_N) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant_pt ? SETUP : IDLE;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done) state_nxt = grant_pt ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        psel      = state[0];
        penable   = state[1];
        req_ready = '0;
        if (grant_pt && APB_ARESET_N) req_ready = NUM_REQ'(1) << winner;
    end

    always_ff @(posedge APB_ACLK) begin
        if (!APB_ARESET_N) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (grant_pt) begin
                paddr  <= req[winner].addr;
                pwrite <= req[winner].write;
                pwdata <= req[winner].wdata;
                owner  <= winner;
                rr_ptr <= rr_ptr_nxt;
            end
            // owner/pwrite still describe the finishing transfer here.
            if (done) begin
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_err   <= bus.pslverr || !bus.pready;
                rsp_rdata <= (bus.pready && !pwrite) ? bus.prdata : '0;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.psel      = psel;
    assign bus.penable   = penable;
    assign bus.paddr     = paddr;
    assign bus.pwrite    = pwrite;
    assign bus.pwdata    = pwdata;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Scoreboard bench for apb_rr_master_arb: requester driver, APB slave model, response monitor.
module tb_apb_rr_master_arb;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_rr_master_arb_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_rr_master_arb #(
        .NUM_REQ(NR), .C_APB_ADDR_WIDTH(AW), .C_APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .APB_ACLK(clk), .APB_ARESET_N(rst_n), .bus(bus)
    );

    typedef struct { int id; logic [DW-1:0] rdata; logic err; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; } apb_t;

    rsp_t rsp_q[$];
    apb_t apb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int          sl_wait  = 0;
    logic        sl_hang  = 1'b0;
    logic        sl_err   = 1'b0;
    logic [DW-1:0] sl_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // APB slave: pops the expected transfer at SETUP, checks payload every selected cycle.
    initial begin
        apb_t cur;
        int   acc;
        cur = '{addr: '0, wr: 1'b0, wdata: '0};
        acc = 0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.psel && !bus.penable) begin
                chk("apb_setup_expected", 64'(apb_q.size() > 0), 64'd1);
                if (apb_q.size() > 0) cur = apb_q.pop_front();
            end
            if (bus.psel) begin
                chk("paddr", 64'(bus.paddr), 64'(cur.addr));
                chk("pwrite", 64'(bus.pwrite), 64'(cur.wr));
                if (cur.wr) chk("pwdata", 64'(bus.pwdata), 64'(cur.wdata));
            end
            if (bus.psel && bus.penable) begin
                bus.pready  = !sl_hang && (acc >= sl_wait);
                bus.prdata  = sl_rdata;
                bus.pslverr = sl_err;
                acc++;
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
                acc = 0;
            end
        end
    end

    // Response monitor.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                chk("rsp_expected", 64'(rsp_q.size() > 0), 64'd1);
                if (rsp_q.size() > 0) begin
                    e = rsp_q.pop_front();
                    chk("rsp_valid", 64'(bus.rsp_valid), 64'(NR'(1) << e.id));
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    task automatic drive(input int id, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        bus.req_valid[id]          = 1'b1;
        bus.req_addr[id*AW +: AW]  = a;
        bus.req_write[id]          = w;
        bus.req_wdata[id*DW +: DW] = d;
    endtask

    // Called at a negedge; returns at the negedge of the SETUP cycle with valid dropped.
    task automatic wait_grant(input int id);
        int n;
        n = 0;
        #1;
        while (!bus.req_ready[id] && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("grant_%0d", id), 64'(bus.req_ready), 64'(NR'(1) << id));
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
    endtask

    // Counts ACCESS cycles; returns at the negedge of the cycle after the last one.
    task automatic count_access(output int n);
        n = 0;
        @(negedge clk);
        while (bus.penable && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, g, cyc, first, last;
        logic [NR-1:0] exp_g;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;

        // Reset with requests pending: no grant, all outputs low.
        rst_n = 1'b0;
        @(negedge clk);
        bus.req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_psel", 64'(bus.psel), 64'd0);
        chk("rst_penable", 64'(bus.penable), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Wait states then slave error on a write.
        sl_wait = 3; sl_err = 1'b1; sl_rdata = 32'hFFFF_FFFF;
        apb_q.push_back('{addr: 32'h20, wr: 1'b1, wdata: 32'h1234_5678});
        rsp_q.push_back('{id: 0, rdata: 32'h0, err: 1'b1});
        drive(0, 32'h20, 1'b1, 32'h1234_5678);
        wait_grant(0);
        count_access(n);
        chk("ws_access_cycles", 64'(n), 64'd4);
        chk("ws_rsp_valid", 64'(bus.rsp_valid), 64'd1);

        // Single zero-wait read with cycle-exact timing.
        sl_wait = 0; sl_err = 1'b0; sl_rdata = 32'hDEAD_BEEF;
        apb_q.push_back('{addr: 32'h10, wr: 1'b0, wdata: 32'h0});
        rsp_q.push_back('{id: 0, rdata: 32'hDEAD_BEEF, err: 1'b0});
        drive(0, 32'h10, 1'b0, 32'h0);
        #1 chk("rd_ready_N", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        chk("rd_psel_N1", 64'(bus.psel), 64'd1);
        chk("rd_penable_N1", 64'(bus.penable), 64'd0);
        @(negedge clk);
        chk("rd_psel_N2", 64'(bus.psel), 64'd1);
        chk("rd_penable_N2", 64'(bus.penable), 64'd1);
        @(negedge clk);
        chk("rd_rsp_N3", 64'(bus.rsp_valid), 64'd1);
        chk("rd_psel_N3", 64'(bus.psel), 64'd0);

        // Reset during an ACCESS wait state: transfer aborted, no response.
        sl_wait = 20;
        apb_q.push_back('{addr: 32'h30, wr: 1'b1, wdata: 32'hA5A5_A5A5});
        drive(0, 32'h30, 1'b1, 32'hA5A5_A5A5);
        wait_grant(0);
        @(negedge clk);
        @(negedge clk);
        chk("mr_in_access", 64'(bus.penable), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_psel", 64'(bus.psel), 64'd0);
        chk("mr_penable", 64'(bus.penable), 64'd0);
        chk("mr_paddr", 64'(bus.paddr), 64'd0);
        chk("mr_pwrite", 64'(bus.pwrite), 64'd0);
        chk("mr_pwdata", 64'(bus.pwdata), 64'd0);
        chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mr_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("mr_rsp_err", 64'(bus.rsp_err), 64'd0);
        sl_wait = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters stream writes: 0 wins first after reset, then alternate.
        sl_err = 1'b0; sl_rdata = 32'h5555_5555;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                apb_q.push_back('{addr: 32'h4, wr: 1'b1, wdata: 32'h0000_0A00});
                rsp_q.push_back('{id: 0, rdata: 32'h0, err: 1'b0});
            end else begin
                apb_q.push_back('{addr: 32'h8, wr: 1'b1, wdata: 32'h0000_0B01});
                rsp_q.push_back('{id: 1, rdata: 32'h0, err: 1'b0});
            end
        end
        drive(0, 32'h4, 1'b1, 32'h0000_0A00);
        drive(1, 32'h8, 1'b1, 32'h0000_0B01);
        g = 0; cyc = 0; first = 0; last = 0;
        while (g < 4 && cyc < 40) begin
            #1;
            if (g > 0) begin
                chk("rr_psel", 64'(bus.psel), 64'd1);
                chk("rr_penable", 64'(bus.penable), 64'(((cyc - first) % 2) == 0));
            end
            if (bus.req_ready != '0) begin
                exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
                chk("rr_grant", 64'(bus.req_ready), 64'(exp_g));
                if (g > 0) chk("rr_spacing", 64'(cyc - last), 64'd2);
                else first = cyc;
                last = cyc;
                g++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.req_valid = '0;
        chk("rr_grant_count", 64'(g), 64'd4);
        n = 0;
        while (rsp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never ready: terminated after 4 ACCESS cycles with error.
        sl_hang = 1'b1; sl_rdata = 32'h1111_1111;
        apb_q.push_back('{addr: 32'h40, wr: 1'b0, wdata: 32'h0});
        rsp_q.push_back('{id: 1, rdata: 32'h0, err: 1'b1});
        drive(1, 32'h40, 1'b0, 32'h0);
        wait_grant(1);
        count_access(n);
        chk("to_access_cycles", 64'(n), 64'd4);
        chk("to_psel_drop", 64'(bus.psel), 64'd0);
        chk("to_rsp_valid", 64'(bus.rsp_valid), 64'd2);

        // Ready on the limit cycle: normal completion.
        sl_hang = 1'b0; sl_wait = 3; sl_rdata = 32'hCAFE_F00D;
        apb_q.push_back('{addr: 32'h44, wr: 1'b0, wdata: 32'h0});
        rsp_q.push_back('{id: 1, rdata: 32'hCAFE_F00D, err: 1'b0});
        drive(1, 32'h44, 1'b0, 32'h0);
        wait_grant(1);
        count_access(n);
        chk("to_edge_access_cycles", 64'(n), 64'd4);
        chk("to_edge_rsp_valid", 64'(bus.rsp_valid), 64'd2);
`endif

        n = 0;
        while ((rsp_q.size() > 0 || apb_q.size() > 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        chk("apb_q_drained", 64'(apb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
